// File: rtl/hafsa_sopc_boutons_ctrl.sv
// rtl/hafsa_sopc_boutons_ctrl.sv - two-button debouncer with Avalon-MM edge-capture/irq registers
module hafsa_sopc_boutons_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic [1:0]  in_port,
    output logic        irq
);

    localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

    logic [1:0] sync_meta;
    logic [1:0] sync_level;
    logic [1:0] debounced;
    logic [1:0] press;
    logic [1:0] edge_capture;
    logic [1:0] edge_clear;
    logic [1:0] irq_mask;
    logic [1:0] rd_mux;
    logic [1:0] rd_q;
    logic       mask_we;
    logic       unused_wdata;

    assign unused_wdata = ^writedata[31:2];

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_meta  <= 2'b11;
            sync_level <= 2'b11;
        end else begin
            sync_meta  <= in_port;
            sync_level <= sync_meta;
        end
    end

    // Any cycle where the synchronized level matches the accepted level restarts the count.
    for (genvar i = 0; i < 2; i++) begin : g_bit
        logic [15:0] count;
        logic        level;
        logic        settle;

        assign settle       = (sync_level[i] != level) && (count == CNT_LAST);
        assign debounced[i] = level;
        assign press[i]     = settle && level;

        always_ff @(posedge clk) begin
            if (reset) begin
                count <= '0;
                level <= 1'b1;
            end else if (sync_level[i] == level) begin
                count <= '0;
            end else if (settle) begin
                count <= '0;
                level <= sync_level[i];
            end else begin
                count <= count + 16'd1;
            end
        end
    end

    assign edge_clear = (write && address == 2'd3) ? writedata[1:0] : 2'b00;
    assign mask_we    = write && address == 2'd2;

    always_comb begin
        rd_mux = 2'b00;
        case (address)
            2'd0:    rd_mux = debounced;
            2'd1:    rd_mux = sync_level;
            2'd2:    rd_mux = irq_mask;
            default: rd_mux = edge_capture;
        endcase
    end

    // A press landing in the same cycle as its clear wins, so no press is lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            edge_capture <= 2'b00;
            irq_mask     <= 2'b00;
            rd_q         <= 2'b00;
        end else begin
            edge_capture <= (edge_capture & ~edge_clear) | press;
            if (mask_we) begin
                irq_mask <= writedata[1:0];
            end
            if (read) begin
                rd_q <= rd_mux;
            end
        end
    end

    assign readdata = {30'b0, rd_q};
    assign irq      = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_hafsa_sopc_boutons_ctrl.sv
// tb/tb_hafsa_sopc_boutons_ctrl.sv - directed vector bench for hafsa_sopc_boutons_ctrl
module tb_hafsa_sopc_boutons_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [1:0]  in_port;
    logic        irq;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [1:0]  addr;
        logic        rd;
        logic        wr;
        logic [31:0] wdata;
        logic [1:0]  inp;
        logic [31:0] exp_rd;
        logic        exp_irq;
    } vec_t;

    vec_t vecs[25];

    hafsa_sopc_boutons_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .address   (address),
        .read      (read),
        .write     (write),
        .writedata (writedata),
        .readdata  (readdata),
        .in_port   (in_port),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [1:0] a, input logic r, input logic w,
                                input logic [31:0] d, input logic [1:0] p,
                                input logic [31:0] er, input logic ei);
        vec_t v;
        v.addr = a; v.rd = r; v.wr = w; v.wdata = d; v.inp = p;
        v.exp_rd = er; v.exp_irq = ei;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic do_read(input logic [1:0] a, input logic [31:0] exp, input string name);
        address = a; read = 1'b1;
        tick();
        read = 1'b0;
        check(name, readdata, exp);
    endtask

    task automatic do_write(input logic [1:0] a, input logic [31:0] d);
        address = a; writedata = d; write = 1'b1;
        tick();
        write = 1'b0; writedata = '0;
    endtask

    initial begin
        vecs[0]  = mk(2'd0, 1, 0, 0, 2'b11, 32'h3, 0);
        vecs[1]  = mk(2'd2, 1, 0, 0, 2'b11, 32'h0, 0);
        vecs[2]  = mk(2'd3, 1, 0, 0, 2'b11, 32'h0, 0);
        vecs[3]  = mk(2'd1, 1, 0, 0, 2'b11, 32'h3, 0);
        vecs[4]  = mk(2'd0, 0, 0, 0, 2'b10, 32'h3, 0);
        vecs[5]  = mk(2'd1, 1, 0, 0, 2'b10, 32'h3, 0);
        vecs[6]  = mk(2'd0, 1, 0, 0, 2'b10, 32'h3, 0);
        vecs[7]  = mk(2'd1, 1, 0, 0, 2'b10, 32'h2, 0);
        vecs[8]  = mk(2'd0, 1, 0, 0, 2'b10, 32'h3, 0);
        vecs[9]  = mk(2'd0, 1, 0, 0, 2'b10, 32'h3, 0);
        vecs[10] = mk(2'd0, 1, 0, 0, 2'b10, 32'h2, 0);
        vecs[11] = mk(2'd3, 1, 0, 0, 2'b10, 32'h1, 0);
        vecs[12] = mk(2'd2, 1, 1, 1, 2'b10, 32'h0, 1);
        vecs[13] = mk(2'd2, 1, 0, 0, 2'b10, 32'h1, 1);
        vecs[14] = mk(2'd0, 0, 0, 0, 2'b00, 32'h1, 1);
        vecs[15] = mk(2'd0, 0, 0, 0, 2'b00, 32'h1, 1);
        vecs[16] = mk(2'd0, 0, 0, 0, 2'b00, 32'h1, 1);
        vecs[17] = mk(2'd0, 0, 0, 0, 2'b10, 32'h1, 1);
        vecs[18] = mk(2'd0, 0, 0, 0, 2'b10, 32'h1, 1);
        vecs[19] = mk(2'd0, 0, 0, 0, 2'b10, 32'h1, 1);
        vecs[20] = mk(2'd0, 1, 0, 0, 2'b10, 32'h2, 1);
        vecs[21] = mk(2'd3, 1, 0, 0, 2'b10, 32'h1, 1);
        vecs[22] = mk(2'd0, 0, 1, 0, 2'b10, 32'h1, 1);
        vecs[23] = mk(2'd0, 1, 0, 0, 2'b10, 32'h2, 1);
        vecs[24] = mk(2'd1, 1, 0, 0, 2'b10, 32'h2, 1);

        reset = 1'b1; address = '0; read = 1'b0; write = 1'b0;
        writedata = '0; in_port = 2'b11;
        idle(2);
        check("reset_readdata", readdata, 32'h0);
        check("reset_irq", {31'b0, irq}, 32'h0);
        reset = 1'b0;

        for (int i = 0; i < 25; i++) begin
            address = vecs[i].addr; read = vecs[i].rd; write = vecs[i].wr;
            writedata = vecs[i].wdata; in_port = vecs[i].inp;
            tick();
            read = 1'b0; write = 1'b0; writedata = '0;
            check($sformatf("vec%0d_readdata", i), readdata, vecs[i].exp_rd);
            check($sformatf("vec%0d_irq", i), {31'b0, irq}, {31'b0, vecs[i].exp_irq});
        end

        // Both buttons captured, then per-bit write-1-to-clear.
        in_port = 2'b00;
        idle(6);
        do_read(2'd3, 32'h3, "both_captured");
        do_write(2'd2, 32'hFFFF_FFFF);
        do_read(2'd2, 32'h3, "mask_upper_bits_dropped");
        do_write(2'd3, 32'h1);
        check("clr0_irq_stays", {31'b0, irq}, 32'h1);
        do_read(2'd3, 32'h2, "clr0_capture");
        do_write(2'd3, 32'h2);
        check("clr1_irq_drops", {31'b0, irq}, 32'h0);
        do_read(2'd3, 32'h0, "clr1_capture");
        in_port = 2'b11;
        idle(8);
        do_read(2'd0, 32'h3, "release_level");
        do_read(2'd3, 32'h0, "release_no_capture");

        // Clear and a fresh press of bit 0 on the same edge.
        in_port = 2'b10;
        idle(6);
        check("press0_irq", {31'b0, irq}, 32'h1);
        in_port = 2'b11;
        idle(8);
        in_port = 2'b10;
        idle(5);
        do_write(2'd3, 32'h1);
        check("clr_vs_press_irq", {31'b0, irq}, 32'h1);
        do_read(2'd3, 32'h1, "clr_vs_press_capture");
        do_read(2'd0, 32'h2, "clr_vs_press_level");
        do_write(2'd3, 32'h3);
        in_port = 2'b11;
        idle(8);
        do_read(2'd3, 32'h0, "cleanup_capture");

        // Reset two counts into a press discards it; the press must then run its full course.
        in_port = 2'b10;
        idle(4);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midreset_readdata", readdata, 32'h0);
        check("midreset_irq", {31'b0, irq}, 32'h0);
        do_read(2'd0, 32'h3, "after_reset_level");
        do_read(2'd3, 32'h0, "after_reset_capture");
        do_read(2'd2, 32'h0, "after_reset_mask");
        tick();
        do_read(2'd0, 32'h3, "restart_level_e5");
        do_read(2'd3, 32'h0, "restart_capture_e6");
        do_read(2'd3, 32'h1, "restart_capture_e7");
        do_read(2'd0, 32'h2, "restart_level_e8");
        check("restart_irq_masked", {31'b0, irq}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
